sb_pkt_fifo: RTL and testbench

Store-and-forward packet FIFO for switchboard streams: it accepts 256-bit switchboard words (data/dest/last) and releases them downstream only once a whole packet, terminated by `last`, has been stored. It sits directly downstream of the `QUEUE_TO_SB_SIM` RX port and feeds the data-processing loopback and `SB_TO_QUEUE_SIM` TX port. It decouples bursty host-side delivery from the RTL consumer and guarantees packets are presented contiguously.

---
 rtl/sb_pkt_fifo.sv | 83 ++++++++
 tb/tb_sb_pkt_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sb_pkt_fifo.sv
// Store-and-forward packet FIFO for switchboard words {data, dest, last}.
// Define SB_PKT_FIFO_CUT_THROUGH_EN to forward words as soon as they are stored.
module sb_pkt_fifo #(
  parameter int DW    = 256,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic [31:0]   in_dest,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic [31:0]   out_dest,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic [AW:0]   pkts
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_data [DEPTH];
  logic [31:0]   mem_dest [DEPTH];
  logic          mem_last [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          pop_last;

  assign in_ready = (count != FULL);

`ifdef SB_PKT_FIFO_CUT_THROUGH_EN
  assign out_valid = (count != '0);
`else
  // The full term lets a packet longer than the FIFO drain instead of deadlocking.
  assign out_valid = (pkts != '0) || (count == FULL);
`endif

  assign out_data = mem_data[rd_ptr];
  assign out_dest = mem_dest[rd_ptr];
  assign out_last = mem_last[rd_ptr];

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign pop_last = mem_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_dest[wr_ptr] <= in_dest;
      mem_last[wr_ptr] <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pkts   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      pkts <= pkts + (AW+1)'(push && in_last) - (AW+1)'(pop && pop_last);
    end
  end

endmodule

// File: tb/tb_sb_pkt_fifo.sv
// Self-checking bench for sb_pkt_fifo: directed vector table plus hand-written
// sequences for full, oversize, wrap-around streaming and mid-packet reset.
module tb_sb_pkt_fifo;

  localparam int DW = 256;

  typedef struct {
    logic [DW-1:0] data;
    logic [31:0]   dest;
    logic          last;
  } word_t;

  typedef struct {
    logic          iv;
    logic [DW-1:0] idata;
    logic [31:0]   idest;
    logic          ilast;
    logic          ordy;
    logic          eov;
    logic          eir;
    logic [4:0]    ecnt;
    logic [4:0]    epkts;
    logic          chk;
    logic [DW-1:0] edata;
    logic [31:0]   edest;
    logic          elast;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic [31:0]   in_dest;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [31:0]   out_dest;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    count;
  logic [4:0]    pkts;

  int checks = 0;
  int errors = 0;

  word_t sendQ[$];
  word_t expQ[$];
  vec_t  vecs[13];

  sb_pkt_fifo #(.DW(DW), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_dest(out_dest), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .pkts(pkts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [31:0] n);
    return {8{n}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid  = v.iv;
    in_data   = v.idata;
    in_dest   = v.idest;
    in_last   = v.ilast;
    out_ready = v.ordy;
  endtask

  task automatic checkState(input string tag, input logic eov, input logic eir,
                            input logic [4:0] ecnt, input logic [4:0] epkts);
    checkOutput({tag, " out_valid"}, DW'(out_valid), DW'(eov));
    checkOutput({tag, " in_ready"}, DW'(in_ready), DW'(eir));
    checkOutput({tag, " count"}, DW'(count), DW'(ecnt));
    checkOutput({tag, " pkts"}, DW'(pkts), DW'(epkts));
  endtask

  // Drives sendQ upstream and checks every popped word against expQ in order.
  task automatic runStream(input bit randomReady, input int budget, input string tag);
    int cycles;
    int modelCount;
    word_t w;
    cycles = 0;
    modelCount = expQ.size();
    while ((sendQ.size() != 0 || expQ.size() != 0) && cycles < budget) begin
      in_valid = (sendQ.size() != 0);
      if (in_valid) begin
        in_data = sendQ[0].data;
        in_dest = sendQ[0].dest;
        in_last = sendQ[0].last;
      end
      out_ready = randomReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      checkOutput({tag, " count"}, DW'(count), DW'(modelCount));
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput({tag, " unexpected pop"}, DW'(1), DW'(0));
        end else begin
          w = expQ.pop_front();
          checkOutput({tag, " data"}, out_data, w.data);
          checkOutput({tag, " dest"}, DW'(out_dest), DW'(w.dest));
          checkOutput({tag, " last"}, DW'(out_last), DW'(w.last));
          modelCount--;
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(sendQ.pop_front());
        modelCount++;
      end
      step();
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (cycles >= budget) begin
      checkOutput({tag, " timeout"}, DW'(cycles), DW'(budget - 1));
    end
    checkOutput({tag, " final count"}, DW'(count), DW'(0));
  endtask

  initial begin
    word_t w;
    vecs[0]  = '{1'b1, {32{8'h01}}, 32'd5, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, '0, 32'd0, 1'b0};
    vecs[1]  = '{1'b0, '0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd1, 1'b1, {32{8'h01}}, 32'd5, 1'b1};
    vecs[2]  = '{1'b0, '0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, '0, 32'd0, 1'b0};
    vecs[3]  = '{1'b1, pat(32'hA0), 32'd1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, '0, 32'd0, 1'b0};
    vecs[4]  = '{1'b1, pat(32'hB0), 32'd2, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 1'b0, '0, 32'd0, 1'b0};
    vecs[5]  = '{1'b1, pat(32'hC0), 32'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 1'b0, '0, 32'd0, 1'b0};
    vecs[6]  = '{1'b0, '0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd1, 1'b1, pat(32'hA0), 32'd1, 1'b0};
    vecs[7]  = '{1'b0, '0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 5'd1, 1'b1, pat(32'hB0), 32'd2, 1'b0};
    vecs[8]  = '{1'b0, '0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd1, 1'b1, pat(32'hC0), 32'd3, 1'b1};
    vecs[9]  = '{1'b1, pat(32'hD0), 32'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, '0, 32'd0, 1'b0};
    vecs[10] = '{1'b1, pat(32'hE0), 32'd8, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 5'd1, 1'b1, pat(32'hD0), 32'd7, 1'b1};
    vecs[11] = '{1'b0, '0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd1, 1'b1, pat(32'hE0), 32'd8, 1'b1};
    vecs[12] = '{1'b0, '0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, '0, 32'd0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0; in_last = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    checkState("reset", 1'b0, 1'b1, 5'd0, 5'd0);

    $display("[TB] directed vectors");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkState($sformatf("vec%0d", i), vecs[i].eov, vecs[i].eir, vecs[i].ecnt, vecs[i].epkts);
      if (vecs[i].chk) begin
        checkOutput($sformatf("vec%0d data", i), out_data, vecs[i].edata);
        checkOutput($sformatf("vec%0d dest", i), DW'(out_dest), DW'(vecs[i].edest));
        checkOutput($sformatf("vec%0d last", i), DW'(out_last), DW'(vecs[i].elast));
      end
      step();
    end

    $display("[TB] fill to full");
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w = '{pat(32'h100 + i), 32'(i), (i == 15)};
      in_valid = 1'b1; in_data = w.data; in_dest = w.dest; in_last = w.last;
      expQ.push_back(w);
      step();
    end
    in_data = pat(32'hDEAD); in_last = 1'b1;
    checkState("full", 1'b1, 1'b0, 5'd16, 5'd1);
    step();
    in_valid = 1'b0;
    checkState("full hold", 1'b1, 1'b0, 5'd16, 5'd1);
    runStream(1'b0, 100, "drain");
    checkOutput("drain in_ready", DW'(in_ready), DW'(1));

    $display("[TB] oversize packet");
    for (int i = 0; i < 16; i++) begin
      w = '{pat(32'h200 + i), 32'(100 + i), 1'b0};
      in_valid = 1'b1; in_data = w.data; in_dest = w.dest; in_last = 1'b0;
      expQ.push_back(w);
      step();
    end
    in_valid = 1'b0;
    checkState("oversize full", 1'b1, 1'b0, 5'd16, 5'd0);
    for (int i = 16; i < 20; i++) begin
      sendQ.push_back('{pat(32'h200 + i), 32'(100 + i), (i == 19)});
    end
    runStream(1'b0, 200, "oversize");

    $display("[TB] random wrap-around stream");
    for (int p = 0; p < 100; p++) begin
      sendQ.push_back('{pat($urandom), 32'(p), 1'b0});
      sendQ.push_back('{pat($urandom), 32'(p), 1'b1});
    end
    runStream(1'b1, 3000, "stream");

    $display("[TB] reset mid-packet");
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = pat(32'h300 + i); in_dest = 32'd9; in_last = 1'b0;
      step();
    end
    checkOutput("pre-reset count", DW'(count), DW'(2));
    rst = 1'b1; in_last = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checkState("mid reset", 1'b0, 1'b1, 5'd0, 5'd0);
    sendQ.push_back('{pat(32'h400), 32'd11, 1'b0});
    sendQ.push_back('{pat(32'h401), 32'd11, 1'b1});
    runStream(1'b0, 50, "post-reset");
    checkState("end", 1'b0, 1'b1, 5'd0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
